// File: rtl/fb_burst_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_burst_writer: FIFO-to-frame-buffer burst writer with frame wrap/flush |
// | Optional ping-pong banks: FB_DOUBLE_BUFFER_EN.        Revision: 1.0      |
// +--------------------------------------------------------------------------+
module fb_burst_writer #(
  parameter int PIX_W     = 12,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BURST_LEN = 10
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_flush,
  input  logic                           i_req,
  output logic                           o_rd,
  input  logic [PIX_W-1:0]               i_rdata,
  input  logic                           i_almostempty,
  output logic                           o_mem_wr,
  output logic [$clog2(H_RES*V_RES):0]   o_mem_waddr,
  output logic [PIX_W-1:0]               o_mem_wdata,
  output logic                           o_frame_done,
  output logic                           o_rd_bank,
  output logic                           o_busy
);

  localparam int FRAME_PIX = H_RES * V_RES;
  localparam int ADDR_W    = $clog2(FRAME_PIX);
  localparam int BC_W      = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(FRAME_PIX - 1);
  localparam logic [BC_W-1:0]   LAST_BEAT = BC_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [BC_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0] rd_pix;
  logic [ADDR_W-1:0] wr_pix;
  logic              rd;
  logic              mem_wr;
  logic              frame_done;
  logic              busy;
  logic              wr_bank;
  logic              rd_bank;

  // rd_pix tracks the pixel index of the read being issued, wr_pix the one being written.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      rd_pix     <= '0;
      wr_pix     <= '0;
      rd         <= 1'b0;
      mem_wr     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_wr     <= rd & ~i_flush;
      frame_done <= rd & ~i_flush & (rd_pix == LAST_PIX);
      if (i_flush) begin
        state    <= IDLE;
        beat_cnt <= '0;
        rd_pix   <= '0;
        wr_pix   <= '0;
        rd       <= 1'b0;
        busy     <= 1'b0;
      end else begin
        if (mem_wr) begin
          wr_pix <= (wr_pix == LAST_PIX) ? '0 : wr_pix + 1'b1;
        end
        if (rd) begin
          rd_pix <= (rd_pix == LAST_PIX) ? '0 : rd_pix + 1'b1;
        end
        case (state)
          IDLE: begin
            if (i_req && !i_almostempty) begin
              state    <= BURST;
              rd       <= 1'b1;
              busy     <= 1'b1;
              beat_cnt <= '0;
            end
          end
          BURST: begin
            // The last pixel of a frame cuts the burst short so each frame starts on a fresh burst.
            if ((beat_cnt == LAST_BEAT) || (rd_pix == LAST_PIX)) begin
              state    <= DRAIN;
              rd       <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          DRAIN: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            rd       <= 1'b0;
            busy     <= 1'b0;
            beat_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  // The bank swap waits for the final write so the reader is only pointed at whole frames.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else if (frame_done) begin
      wr_bank <= ~wr_bank;
      rd_bank <= wr_bank;
    end
  end
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  assign o_rd         = rd;
  assign o_mem_wr     = mem_wr;
  assign o_mem_waddr  = {wr_bank, wr_pix};
  assign o_mem_wdata  = mem_wr ? i_rdata : '0;
  assign o_frame_done = frame_done;
  assign o_rd_bank    = rd_bank;
  assign o_busy       = busy;

endmodule
`default_nettype wire

// File: tb/tb_fb_burst_writer.sv
`default_nettype none
// Scoreboard bench for fb_burst_writer on an 8x4 frame with 5-word bursts.
module tb_fb_burst_writer;

  localparam int PIX_W     = 12;
  localparam int H_RES     = 8;
  localparam int V_RES     = 4;
  localparam int BURST_LEN = 5;
  localparam int FRAME_PIX = H_RES * V_RES;
  localparam int ADDR_W    = $clog2(FRAME_PIX);
`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic req = 1'b0;
  logic ae = 1'b1;
  logic [PIX_W-1:0] rdata = '0;
  logic rd, mem_wr, frame_done, rd_bank, busy;
  logic [ADDR_W:0] waddr;
  logic [PIX_W-1:0] wdata;

  typedef struct {
    logic [ADDR_W:0]  addr;
    logic [PIX_W-1:0] data;
    logic             fd;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   fd_count = 0;
  int   exp_addr = 0;
  logic exp_bank = 1'b0;
  logic rd_last = 1'b0;

  fb_burst_writer #(
    .PIX_W(PIX_W), .H_RES(H_RES), .V_RES(V_RES), .BURST_LEN(BURST_LEN)
  ) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_flush(flush), .i_req(req), .o_rd(rd),
    .i_rdata(rdata), .i_almostempty(ae), .o_mem_wr(mem_wr), .o_mem_waddr(waddr),
    .o_mem_wdata(wdata), .o_frame_done(frame_done), .o_rd_bank(rd_bank), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // FIFO model: supplies a word the cycle after each read and records the write it must cause.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      rd_last  = 1'b0;
      exp_addr = 0;
      exp_bank = 1'b0;
    end else begin
      if (rd_last) begin
        rdata = PIX_W'($urandom);
        if (!flush) begin
          e.addr = {exp_bank, ADDR_W'(exp_addr)};
          e.data = rdata;
          e.fd   = (exp_addr == FRAME_PIX - 1);
          exp_q.push_back(e);
          if (exp_addr == FRAME_PIX - 1) begin
            exp_addr = 0;
            if (DB) exp_bank = ~exp_bank;
          end else begin
            exp_addr++;
          end
        end
      end
      if (flush) exp_addr = 0;
      rd_last = rd;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_done) fd_count++;
      if (mem_wr) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: actual write at addr %0h, required no write", waddr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(waddr), 64'(e.addr));
          check("wr_data", 64'(wdata), 64'(e.data));
          check("wr_frame_done", 64'(frame_done), 64'(e.fd));
        end
      end else if (frame_done) begin
        tests++;
        fails++;
        $display("FAIL frame_done_no_write: actual 1, required 0");
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd"}, 64'(rd), 0);
    check({tag, "_mem_wr"}, 64'(mem_wr), 0);
    check({tag, "_waddr"}, 64'(waddr), 0);
    check({tag, "_wdata"}, 64'(wdata), 0);
    check({tag, "_frame_done"}, 64'(frame_done), 0);
    check({tag, "_rd_bank"}, 64'(rd_bank), 0);
    check({tag, "_busy"}, 64'(busy), 0);
  endtask

  task automatic idle_no_rd(input string name);
    int n;
    n = 0;
    req = 1'b1;
    ae  = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rd) n++;
    end
    check(name, 64'(n), 0);
  endtask

  task automatic run_burst(output int n);
    @(negedge clk);
    @(negedge clk);
    req = 1'b1;
    ae  = 1'b0;
    @(negedge clk);
    ae = 1'b1;
    n  = 0;
    while (rd === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_frame();
    int n;
    for (int b = 0; b < 7; b++) begin
      run_burst(n);
      check("burst_reads", 64'(n), (b == 6) ? 64'd2 : 64'(BURST_LEN));
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int fd0;
    @(negedge clk);
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle_no_rd("idle_no_rd");

    fd0 = fd_count;
    run_burst(n);
    check("first_burst_reads", 64'(n), 64'(BURST_LEN));
    check("busy_in_drain", 64'(busy), 1);
    @(negedge clk);
    check("busy_after_drain", 64'(busy), 0);
    for (int b = 1; b < 7; b++) begin
      run_burst(n);
      check("burst_reads", 64'(n), (b == 6) ? 64'd2 : 64'(BURST_LEN));
    end
    repeat (3) @(negedge clk);
    check("frame1_done_count", 64'(fd_count - fd0), 1);
    check("frame1_rd_bank", 64'(rd_bank), 0);

    run_frame();
    check("frame2_done_count", 64'(fd_count - fd0), 2);
    check("frame2_rd_bank", 64'(rd_bank), 64'(DB));

    // Flush and a start request in the same cycle: flush wins.
    @(negedge clk);
    req   = 1'b1;
    ae    = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ae    = 1'b1;
    check("flush_prio_no_rd", 64'(rd), 0);
    @(negedge clk);
    check("flush_prio_no_rd2", 64'(rd), 0);
    check("flush_idle_rd_bank", 64'(rd_bank), 64'(DB));

    run_burst(n);
    check("frame3_burst_reads", 64'(n), 64'(BURST_LEN));
    @(negedge clk);
    @(negedge clk);
    req = 1'b1;
    ae  = 1'b0;
    @(negedge clk);
    ae = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("flush_4th_read_rd", 64'(rd), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("rd_after_flush", 64'(rd), 0);
    check("busy_after_flush", 64'(busy), 0);
    run_burst(n);
    check("post_flush_burst_reads", 64'(n), 64'(BURST_LEN));
    check("post_flush_rd_bank", 64'(rd_bank), 64'(DB));
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    @(negedge clk);
    req = 1'b1;
    ae  = 1'b0;
    @(negedge clk);
    ae = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_no_rd("idle_no_rd_after_reset");
    run_burst(n);
    check("after_reset_burst_reads", 64'(n), 64'(BURST_LEN));

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fb_burst_writer.md
Name: fb_burst_writer

Overview:
Single-clock, parametrised successor to the camera-side frame-buffer write path.
- Drains pixels from an upstream input FIFO in fixed-length bursts, gated by the FIFO's almost-empty flag.
- Writes the pixels to a frame-buffer RAM write port at sequential addresses, wrapping at the end of each frame.
- New relative to the previous generation: configurable resolution, pixel width and burst length; a frame-done pulse; flush abort; optional ping-pong (double) buffering.

Parameters:
- PIX_W, 12, pixel width in bits.
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- BURST_LEN, 10, FIFO reads per burst. Upstream almost-empty threshold must be at least BURST_LEN.
- Derived, not overridable: FRAME_PIX = H_RES*V_RES; ADDR_W = $clog2(FRAME_PIX).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous abort; restarts the frame at address 0.
- i_req  in  1  enable; bursts start only while high.
- o_rd  out  1  FIFO read strobe.
- i_rdata  in  PIX_W  FIFO read data, valid 1 cycle after o_rd.
- i_almostempty  in  1  FIFO holds fewer than BURST_LEN words.
- o_mem_wr  out  1  RAM write enable.
- o_mem_waddr  out  ADDR_W+1  RAM write address; MSB is the bank bit.
- o_mem_wdata  out  PIX_W  RAM write data.
- o_frame_done  out  1  1-cycle pulse on the write of pixel FRAME_PIX-1.
- o_rd_bank  out  1  bank holding the last complete frame, for the display reader.
- o_busy  out  1  high while in BURST or DRAIN.

Behaviour:
- Reset (async, i_rstn=0): all outputs 0; state IDLE; pixel counter 0; write bank 0; burst counter 0.
- FSM states: IDLE, BURST, DRAIN.
- IDLE -> BURST when i_req=1 and i_almostempty=0, sampled at a clock edge. o_rd rises on the following cycle.
- BURST: o_rd=1 every cycle for BURST_LEN consecutive cycles; i_almostempty is ignored mid-burst. After the BURST_LEN-th read -> DRAIN.
- Early burst end: if the read for pixel FRAME_PIX-1 is issued mid-burst, the burst ends there -> DRAIN. The next frame starts with a fresh burst.
- DRAIN: 1 cycle while the last FIFO word lands -> IDLE. Back-to-back bursts therefore have at least 2 idle o_rd cycles between them.
- o_rd is never asserted in IDLE or DRAIN.
- Write pipeline: o_mem_wr is o_rd delayed by exactly 1 cycle. o_mem_wdata = i_rdata in that cycle. Each o_rd produces exactly one write.
- Address: o_mem_waddr[ADDR_W-1:0] = pixel counter. The counter increments after each write, and after FRAME_PIX-1 wraps to 0. No address is skipped or repeated; the counter never reaches FRAME_PIX.
- o_frame_done is high in the same cycle as the write to address FRAME_PIX-1.
- i_flush=1 at any state:
  - next state IDLE; o_rd=0 next cycle;
  - any write whose o_rd was already issued is suppressed (o_mem_wr=0);
  - pixel counter cleared to 0; no o_frame_done;
  - bank bits unchanged.
- i_flush has priority over burst start in the same cycle.
- i_req dropping mid-burst does not abort the burst; it only blocks the next start.
- Width rules: all counters unsigned. The burst counter is $clog2(BURST_LEN+1) bits.

Optional Feature:
Macro: FB_DOUBLE_BUFFER_EN
- Defined:
  - o_mem_waddr[ADDR_W] = write bank.
  - The write bank toggles on the cycle after the o_frame_done write.
  - o_rd_bank is updated to the bank just completed in the same cycle, so the reader always sees a whole frame.
  - Flush does not toggle either bank.
- Undefined:
  - o_mem_waddr[ADDR_W] tied 0 and o_rd_bank tied 0. Single-buffer operation.
  - All other behaviour identical.

Test Plan:
- Reset: assert i_rstn=0 mid-operation -> all outputs 0 immediately. After release with i_almostempty=1 for 20 cycles -> o_rd stays 0.
- Single burst (defaults): i_req=1, i_almostempty low for 1 cycle, random i_rdata -> 10 consecutive o_rd; o_mem_wr 1 cycle later at addresses 0..9; data matches a FIFO model queue.
- Full frame (defaults): 30720 bursts -> 307200 writes with no skipped address; o_frame_done exactly once, at address 307199; next write at address 0.
- Small frame (H_RES=8, V_RES=4, BURST_LEN=5): frame end at 31 truncates the 7th burst after 2 reads; the next burst starts at address 0.
- Flush: assert i_flush on the 4th read of a burst -> that read's write suppressed; o_rd low next cycle; next burst writes start at address 0.
- FB_DOUBLE_BUFFER_EN: two full small frames -> frame 1 writes bank 0 and o_rd_bank becomes 0; frame 2 writes bank 1 and o_rd_bank becomes 1; a flush between frames leaves both banks unchanged.
